nrs_ls_est_ctrl: RTL and testbench
==================================

Name: nrs_ls_est_ctrl

Overview:
- Sequences the signed NRS complex multiplier (LS channel estimator) for one NB-IoT subframe.
- Computes the 4 NRS pilot subcarrier positions (2 NRS symbols x 2 pilots) and fetches each received RE from the resource-grid buffer.
- Drives the multiplier's write enable, write address and pilot sign bits for each fetched RE.
- Streams the 4 stored estimates to the interpolator over a valid/ready handshake.

Parameters:
- SC_W, 4, subcarrier index width (12 subcarriers, 0..11).
- TIMEOUT_CYC, 63, maximum cycles to wait for grid_rd_valid after a request; must be 1..255.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock; reset is synchronous and active-low.
- start  in  1  single-cycle pulse: estimate one subframe.
- abort  in  1  force return to IDLE.
- v_shift  in  3  NCellID mod 6, sampled on accepted start.
- nrs_bits  in  8  pilot signs; bits {2p+1,2p} = {nrs_i,nrs_r} of pilot p (1 = negative).
- nrs_valid  in  1  nrs_bits valid (level).
- grid_rd_req  out  1  grid read request.
- grid_sym  out  1  NRS symbol select: 0 = first, 1 = second.
- grid_sc  out  SC_W  subcarrier index.
- grid_rd_valid  in  1  returned RE present on multiplier rx_r/rx_i this cycle.
- mult_en  out  1  multiplier write enable.
- mult_wr_addr  out  2  multiplier write address.
- nrs_r, nrs_i  out  1  pilot sign bits to the multiplier.
- mult_rd_addr  out  2  multiplier read address.
- est_valid  out  1  estimate on multiplier real_part_reg/imag_part_reg is valid.
- est_ready  in  1  interpolator accepts the estimate.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse after the last estimate is transferred.
- err_timeout  out  1  sticky grid-timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (rst low at posedge clk): state IDLE.
  - All outputs 0: grid_rd_req, grid_sym, grid_sc, mult_en, mult_wr_addr, nrs_r, nrs_i, mult_rd_addr, est_valid, busy, done, err_timeout.
  - Pilot index p = 0; latched v_shift and nrs_bits = 0.
  - Reset asserted mid-operation takes effect on the next edge; no write or transfer completes in that cycle.
- Pilot positions, p = 0..3:
  - sym = p[1].
  - sc = 6*p[0] + ((v_shift + 3*p[1]) mod 6).
  - v_shift values 6 or 7 are treated as v_shift - 6.
- State IDLE:
  - start accepted only in IDLE; start in any other state is ignored.
  - On start: latch v_shift, clear err_timeout, p = 0, go to WAIT_NRS.
- State WAIT_NRS: when nrs_valid = 1, latch nrs_bits and go to REQ (1 cycle minimum).
- State REQ: grid_rd_req = 1 for exactly one cycle with grid_sym/grid_sc of pilot p; timeout counter cleared; go to WAIT_DATA.
- State WAIT_DATA: grid_sym/grid_sc held.
  - grid_rd_valid = 1:
    - mult_en = 1 combinationally in that same cycle.
    - mult_wr_addr = p; nrs_r/nrs_i = latched bits of pilot p, all held stable throughout WAIT_DATA.
    - If p = 3, go to OUT with mult_rd_addr = 0; otherwise p = p+1 and go to REQ.
  - Counter reaches TIMEOUT_CYC with no grid_rd_valid: set err_timeout, go to IDLE; no done pulse.
  - grid_rd_valid outside WAIT_DATA is ignored and mult_en stays 0.
- State OUT:
  - est_valid = 1, mult_rd_addr = index k.
  - Transfer occurs on est_valid & est_ready: k = k+1.
  - After the transfer with k = 3: done = 1 next cycle, state IDLE.
  - est_ready low stalls with address and valid held.
- Throughput: 4 pilots need at least 8 cycles (REQ + WAIT_DATA each).
- abort in any non-IDLE state: next state IDLE; grid_rd_req, mult_en, est_valid deasserted from the next cycle.
  - In the abort cycle mult_en may still fire if grid_rd_valid = 1 (the write completes).
  - No done pulse; err_timeout unchanged.
- Simultaneous events:
  - abort and start in IDLE: abort wins, start ignored.
  - rst overrides everything.

Test Plan:
- v_shift = 2, nrs_valid held, grid_rd_valid 1 cycle after each request, est_ready = 1:
  - grid requests (sym,sc) = (0,2),(0,8),(1,5),(1,11).
  - mult_en with wr_addr 0,1,2,3; OUT reads rd_addr 0..3 in 4 cycles; done one cycle after the 4th transfer.
- nrs_bits = 8'b10_01_11_00 -> (nrs_r,nrs_i) per pilot 0..3 = (0,0),(1,1),(1,0),(0,1), each coincident with its mult_en.
- v_shift = 5 -> sc sequence 5,11,2,8.
- v_shift = 7 -> same as v_shift = 1: sc 1,7,4,10.
- est_ready toggles 1,0,0,1,1,0,1 -> exactly 4 transfers; rd_addr held during stalls; done follows the 4th transfer.
- Second pilot never answered, TIMEOUT_CYC = 63 -> err_timeout = 1 after 63 wait cycles; IDLE; no done; next start clears err_timeout.
- abort during WAIT_DATA of pilot 2 -> IDLE next cycle, no further mult_en, no done.
- start while busy is ignored.
- Synchronous reset mid-OUT -> all outputs 0 after the edge.

Source files
------------

// File: rtl/nrs_ls_est_ctrl_if.sv
// Handshake and bus bundle between the LS-estimator controller and its
// neighbours: the resource-grid buffer, the NRS multiplier and the interpolator.
interface nrs_ls_est_ctrl_if #(
    parameter int SC_W = 4
);
    logic            start;
    logic            abort;
    logic [2:0]      v_shift;
    logic [7:0]      nrs_bits;
    logic            nrs_valid;
    logic            grid_rd_req;
    logic            grid_sym;
    logic [SC_W-1:0] grid_sc;
    logic            grid_rd_valid;
    logic            mult_en;
    logic [1:0]      mult_wr_addr;
    logic            nrs_r;
    logic            nrs_i;
    logic [1:0]      mult_rd_addr;
    logic            est_valid;
    logic            est_ready;
    logic            busy;
    logic            done;
    logic            err_timeout;

    modport master (
        output start, abort, v_shift, nrs_bits, nrs_valid, grid_rd_valid, est_ready,
        input  grid_rd_req, grid_sym, grid_sc, mult_en, mult_wr_addr, nrs_r, nrs_i,
               mult_rd_addr, est_valid, busy, done, err_timeout
    );

    modport slave (
        input  start, abort, v_shift, nrs_bits, nrs_valid, grid_rd_valid, est_ready,
        output grid_rd_req, grid_sym, grid_sc, mult_en, mult_wr_addr, nrs_r, nrs_i,
               mult_rd_addr, est_valid, busy, done, err_timeout
    );
endinterface

// File: rtl/nrs_ls_est_ctrl.sv
// LS channel-estimate sequencer for one NB-IoT subframe: fetches the 4 NRS
// pilot REs from the grid buffer, feeds them to the signed NRS multiplier
// with the pilot sign bits, then streams the 4 estimates to the interpolator.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | waiting for start
// WAIT_NRS  | waiting for the pilot sign bits (nrs_valid)
// REQ       | one-cycle grid read request for pilot p
// WAIT_DATA | waiting for the RE; multiplier write fires on grid_rd_valid
// OUT       | presenting estimate k to the interpolator
module nrs_ls_est_ctrl #(
    parameter int SC_W        = 4,
    parameter int TIMEOUT_CYC = 63
) (
    input logic               clk,
    input logic               rst,
    nrs_ls_est_ctrl_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, WAIT_NRS, REQ, WAIT_DATA, OUT} state_t;

    localparam logic [7:0] TMR_LOAD = 8'(TIMEOUT_CYC - 1);

    state_t     state;
    logic [1:0] p;
    logic [1:0] p_next;
    logic [2:0] vs;
    logic [7:0] bits;
    logic [7:0] tmr;

    // Subcarrier of pilot pp: 6*pp[0] + ((vs + 3*pp[1]) mod 6), vs already in 0..5.
    function automatic logic [SC_W-1:0] pilot_sc(input logic [2:0] v, input logic [1:0] pp);
        logic [3:0] t;
        t = {1'b0, v} + (pp[1] ? 4'd3 : 4'd0);
        if (t >= 4'd6) t = t - 4'd6;
        t = t + (pp[0] ? 4'd6 : 4'd0);
        return SC_W'(t);
    endfunction

    assign p_next = p + 2'd1;

    // Write strobe must coincide with the returned RE, so it is decoded, not registered.
    assign bus.mult_en = rst && (state == WAIT_DATA) && bus.grid_rd_valid;
    assign bus.busy    = (state != IDLE);

    // Sequencer: state, pilot index, timeout down-counter and registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state            <= IDLE;
            p                <= 2'd0;
            vs               <= 3'd0;
            bits             <= 8'd0;
            tmr              <= 8'd0;
            bus.grid_rd_req  <= 1'b0;
            bus.grid_sym     <= 1'b0;
            bus.grid_sc      <= '0;
            bus.mult_wr_addr <= 2'd0;
            bus.nrs_r        <= 1'b0;
            bus.nrs_i        <= 1'b0;
            bus.mult_rd_addr <= 2'd0;
            bus.est_valid    <= 1'b0;
            bus.done         <= 1'b0;
            bus.err_timeout  <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        vs              <= (bus.v_shift >= 3'd6) ? bus.v_shift - 3'd6 : bus.v_shift;
                        bus.err_timeout <= 1'b0;
                        p               <= 2'd0;
                        state           <= WAIT_NRS;
                    end
                end
                WAIT_NRS: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.nrs_valid) begin
                        bits             <= bus.nrs_bits;
                        bus.grid_rd_req  <= 1'b1;
                        bus.grid_sym     <= 1'b0;
                        bus.grid_sc      <= pilot_sc(vs, 2'd0);
                        bus.mult_wr_addr <= 2'd0;
                        bus.nrs_r        <= bus.nrs_bits[0];
                        bus.nrs_i        <= bus.nrs_bits[1];
                        state            <= REQ;
                    end
                end
                REQ: begin
                    bus.grid_rd_req <= 1'b0;
                    tmr             <= TMR_LOAD;
                    state           <= bus.abort ? IDLE : WAIT_DATA;
                end
                WAIT_DATA: begin
                    if (bus.abort) begin
                        state <= IDLE;
                    end else if (bus.grid_rd_valid) begin
                        if (p == 2'd3) begin
                            bus.est_valid    <= 1'b1;
                            bus.mult_rd_addr <= 2'd0;
                            state            <= OUT;
                        end else begin
                            p                <= p_next;
                            bus.grid_rd_req  <= 1'b1;
                            bus.grid_sym     <= p_next[1];
                            bus.grid_sc      <= pilot_sc(vs, p_next);
                            bus.mult_wr_addr <= p_next;
                            bus.nrs_r        <= bits[{p_next, 1'b0}];
                            bus.nrs_i        <= bits[{p_next, 1'b1}];
                            state            <= REQ;
                        end
                    end else if (tmr == 8'd0) begin
                        bus.err_timeout <= 1'b1;
                        state           <= IDLE;
                    end else begin
                        tmr <= tmr - 8'd1;
                    end
                end
                OUT: begin
                    if (bus.abort) begin
                        bus.est_valid <= 1'b0;
                        state         <= IDLE;
                    end else if (bus.est_ready) begin
                        if (bus.mult_rd_addr == 2'd3) begin
                            bus.est_valid    <= 1'b0;
                            bus.mult_rd_addr <= 2'd0;
                            bus.done         <= 1'b1;
                            state            <= IDLE;
                        end else begin
                            bus.mult_rd_addr <= bus.mult_rd_addr + 2'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nrs_ls_est_ctrl.sv
// Directed bench for the LS-estimate sequencer: pilot positions, sign bits,
// output handshake with stalls, timeout, abort, busy-start and reset.
module tb_nrs_ls_est_ctrl;
    localparam int SC_W = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_done   = 0;

    always #5 clk = ~clk;

    nrs_ls_est_ctrl_if #(.SC_W(SC_W)) bus ();

    nrs_ls_est_ctrl #(.SC_W(SC_W), .TIMEOUT_CYC(63)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count done pulses away from the active edge.
    always @(negedge clk) if (bus.done === 1'b1) n_done++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] all_out();
        return 32'({bus.grid_rd_req, bus.grid_sym, bus.grid_sc, bus.mult_en, bus.mult_wr_addr,
                    bus.nrs_r, bus.nrs_i, bus.mult_rd_addr, bus.est_valid, bus.busy,
                    bus.done, bus.err_timeout});
    endfunction

    // Entered just after the edge that put pilot p in REQ; leaves just after the
    // edge that consumed its RE. exp_ri holds {r,i} per pilot, pilot 0 in [1:0].
    task automatic fetch_pilot(input int p, input logic [3:0] sc, input logic [7:0] exp_ri,
                               input int delay, input bit poke);
        logic [1:0] pp;
        pp = 2'(p);
        check("req_high", 32'(bus.grid_rd_req), 32'd1);
        check("req_sym", 32'(bus.grid_sym), 32'(pp[1]));
        check("req_sc", 32'(bus.grid_sc), 32'(sc));
        step();
        check("req_one_cycle", 32'(bus.grid_rd_req), 32'd0);
        for (int i = 0; i < delay; i++) begin
            check("en_idle", 32'(bus.mult_en), 32'd0);
            if (poke && i == 0) begin
                bus.start   = 1'b1;
                bus.v_shift = 3'd0;
            end
            step();
            bus.start = 1'b0;
        end
        check("sc_held", 32'(bus.grid_sc), 32'(sc));
        bus.grid_rd_valid = 1'b1;
        #1;
        check("mult_en", 32'(bus.mult_en), 32'd1);
        check("wr_addr", 32'(bus.mult_wr_addr), 32'(pp));
        check("nrs_r", 32'(bus.nrs_r), 32'(exp_ri[2*p+1]));
        check("nrs_i", 32'(bus.nrs_i), 32'(exp_ri[2*p]));
        step();
        bus.grid_rd_valid = 1'b0;
    endtask

    // exp_sc holds 4 subcarriers, pilot 0 in [3:0]. ready_pat bit i drives est_ready
    // on OUT cycle i (1 beyond pat_len). Returns the number of OUT cycles.
    task automatic run_subframe(input logic [2:0] vsh, input logic [7:0] bits_in,
                                input logic [7:0] exp_ri, input logic [15:0] exp_sc,
                                input int delay, input bit poke,
                                input logic [15:0] ready_pat, input int pat_len,
                                output int cycles);
        int k;
        int i;
        bus.v_shift   = vsh;
        bus.nrs_bits  = bits_in;
        bus.nrs_valid = 1'b0;
        bus.start     = 1'b1;
        step();
        bus.start   = 1'b0;
        bus.v_shift = 3'd3;
        check("busy_after_start", 32'(bus.busy), 32'd1);
        check("err_clear", 32'(bus.err_timeout), 32'd0);
        step();
        check("wait_nrs_no_req", 32'(bus.grid_rd_req), 32'd0);
        bus.nrs_valid = 1'b1;
        step();
        bus.nrs_valid = 1'b0;
        bus.nrs_bits  = 8'hA5;
        for (int p = 0; p < 4; p++)
            fetch_pilot(p, exp_sc[4*p +: 4], exp_ri, delay, poke && p == 1);
        k = 0;
        i = 0;
        while (k < 4 && i < 32) begin
            bus.est_ready = (i < pat_len) ? ready_pat[i] : 1'b1;
            check("est_valid", 32'(bus.est_valid), 32'd1);
            check("rd_addr", 32'(bus.mult_rd_addr), 32'(k));
            step();
            if (bus.est_ready) k++;
            i++;
        end
        bus.est_ready = 1'b0;
        check("done_pulse", 32'(bus.done), 32'd1);
        check("idle_after_done", 32'(bus.busy), 32'd0);
        check("valid_dropped", 32'(bus.est_valid), 32'd0);
        step();
        check("done_one_cycle", 32'(bus.done), 32'd0);
        cycles = i;
    endtask

    initial begin
        int cyc;
        int n;
        int done_snap;
        bus.start = 1'b0; bus.abort = 1'b0; bus.v_shift = 3'd0; bus.nrs_bits = 8'd0;
        bus.nrs_valid = 1'b0; bus.grid_rd_valid = 1'b0; bus.est_ready = 1'b0;

        step(); step();
        check("reset_outputs", all_out(), 32'd0);
        rst = 1'b1;
        step();

        // abort beats start in IDLE
        bus.start = 1'b1; bus.abort = 1'b1;
        step();
        bus.start = 1'b0; bus.abort = 1'b0;
        check("abort_wins_start", 32'(bus.busy), 32'd0);

        // v_shift 2, signs 10_01_11_00 -> (r,i) = (0,0),(1,1),(1,0),(0,1)
        run_subframe(3'd2, 8'b10_01_11_00, 8'b01_10_11_00, {4'd11, 4'd5, 4'd8, 4'd2},
                     0, 1'b0, 16'h0, 0, cyc);
        check("out_cycles_full_rate", 32'(cyc), 32'd4);

        // v_shift 5, start poked while busy must be ignored
        run_subframe(3'd5, 8'd0, 8'd0, {4'd8, 4'd2, 4'd11, 4'd5}, 1, 1'b1, 16'h0, 0, cyc);
        check("out_cycles_vs5", 32'(cyc), 32'd4);

        // v_shift 7 behaves as 1; est_ready 1,0,0,1,1,0,1
        run_subframe(3'd7, 8'b11_11_11_11, 8'b11_11_11_11, {4'd10, 4'd4, 4'd7, 4'd1},
                     2, 1'b0, 16'h0059, 7, cyc);
        check("out_cycles_stalled", 32'(cyc), 32'd7);
        check("done_count", 32'(n_done), 32'd3);

        // timeout: second pilot never answered
        done_snap = n_done;
        bus.v_shift = 3'd0; bus.nrs_bits = 8'd0; bus.nrs_valid = 1'b1; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        fetch_pilot(0, 4'd0, 8'd0, 0, 1'b0);
        check("req_p1_sc", 32'(bus.grid_sc), 32'd6);
        step();
        n = 0;
        while (bus.err_timeout !== 1'b1 && n < 100) begin
            step();
            n++;
        end
        check("timeout_cycles", 32'(n), 32'd63);
        check("timeout_flag", 32'(bus.err_timeout), 32'd1);
        check("timeout_idle", 32'(bus.busy), 32'd0);
        check("timeout_no_done", 32'(n_done), 32'(done_snap));

        // next start clears the flag; abort in WAIT_DATA of pilot 2
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        check("err_cleared_by_start", 32'(bus.err_timeout), 32'd0);
        step();
        fetch_pilot(0, 4'd0, 8'd0, 0, 1'b0);
        fetch_pilot(1, 4'd6, 8'd0, 0, 1'b0);
        check("req_p2_sc", 32'(bus.grid_sc), 32'd3);
        step();
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_idle", 32'(bus.busy), 32'd0);
        check("abort_no_req", 32'(bus.grid_rd_req), 32'd0);
        bus.grid_rd_valid = 1'b1;
        #1;
        check("abort_no_en", 32'(bus.mult_en), 32'd0);
        step();
        check("idle_valid_ignored", 32'(bus.mult_en), 32'd0);
        bus.grid_rd_valid = 1'b0;
        check("abort_no_done", 32'(n_done), 32'(done_snap));
        check("abort_err_kept", 32'(bus.err_timeout), 32'd0);

        // synchronous reset while stalled in OUT
        bus.v_shift = 3'd2; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        for (int p = 0; p < 4; p++) begin
            logic [15:0] scs;
            scs = {4'd11, 4'd5, 4'd8, 4'd2};
            fetch_pilot(p, scs[4*p +: 4], 8'd0, 0, 1'b0);
        end
        bus.est_ready = 1'b0;
        step();
        check("stall_valid", 32'(bus.est_valid), 32'd1);
        check("stall_addr", 32'(bus.mult_rd_addr), 32'd0);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("reset_mid_out", all_out(), 32'd0);
        step();
        check("reset_stays_idle", all_out(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
